mem_copy_master: RTL and testbench

//  Initiator on the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).

---
 rtl/mem_copy_master.sv | 161 ++++++++++++++++
 tb/tb_mem_copy_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// Block-copy initiator for the picorv32 native memory bus.
// Moves len_words 32-bit words from src_addr to dst_addr in ascending order,
// one read followed by one write per word, with an optional stall timeout.
module mem_copy_master #(
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mem_valid,
  output logic                 mem_instr,
  input  logic                 mem_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata
);

  // Wait counter only needs to reach TIMEOUT-1; the abort fires on that stall cycle.
  localparam int                   WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LAST  = (TIMEOUT > 1) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam bit                   TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [31:0]          WORD_STEP  = 32'd4;
  localparam logic [LEN_WIDTH-1:0] LAST_WORD  = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [31:0]          src_ptr;
  logic [31:0]          dst_ptr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 stall_expired;

  // A job is rejected if either pointer is not on a word boundary.
  function automatic logic misaligned(input logic [31:0] s, input logic [31:0] d);
    return (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
  endfunction

  // The core never fetches instructions through this port.
  assign mem_instr = 1'b0;

  // Current stall cycle is the last one the responder is allowed before we give up.
  always_comb begin
    stall_expired = TIMEOUT_EN && mem_valid && !mem_ready && (wait_cnt == WAIT_LAST);
  end

  // Copy sequencer: all bus outputs are registered and only change on a handshake,
  // an accepted start, a timeout abort or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len_words;
            wait_cnt  <= '0;
            if (misaligned(src_addr, dst_addr)) begin
              // Rejected without touching the bus.
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (len_words == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy      <= 1'b1;
              mem_valid <= 1'b1;
              mem_addr  <= src_addr;
              mem_wstrb <= 4'b0000;
              state     <= S_READ;
            end
          end
        end

        S_READ: begin
          if (mem_ready) begin
            // Read data becomes the write payload; the request stays valid.
            mem_wdata <= mem_rdata;
            mem_addr  <= dst_ptr;
            mem_wstrb <= 4'b1111;
            wait_cnt  <= '0;
            state     <= S_WRITE;
          end else if (stall_expired) begin
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WRITE: begin
          if (mem_ready) begin
            // Pointers wrap modulo 2^32 with no special handling.
            src_ptr   <= src_ptr + WORD_STEP;
            dst_ptr   <= dst_ptr + WORD_STEP;
            remaining <= remaining - LAST_WORD;
            wait_cnt  <= '0;
            if (remaining == LAST_WORD) begin
              mem_valid <= 1'b0;
              mem_wstrb <= 4'b0000;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              mem_addr  <= src_ptr + WORD_STEP;
              mem_wstrb <= 4'b0000;
              state     <= S_READ;
            end
          end else if (stall_expired) begin
            // Words already written are left in place.
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_DONE: begin
          // One-cycle completion slot; a start seen here is dropped.
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: a driver issues copy jobs and pushes the
// expected bus transactions and completion records computed from a reference
// memory; a negedge monitor acts as the memory responder and checks outputs.
module tb_mem_copy_master;

  localparam int TMO = 8;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LW-1:0] len_words;
  logic          busy;
  logic          done;
  logic          error;
  logic          mem_valid;
  logic          mem_instr;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata = 32'h0;

  mem_copy_master #(.LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .error(error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int cyc; bit err; bit aborted; } done_t;

  bus_t  exp_q[$];
  done_t done_q[$];

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];

  int n_vec = 0;
  int n_bad = 0;
  int jobs_done = 0;
  int hs_count = 0;
  int stuck_at = 1 << 30;
  int lat_lo = 0;
  int lat_hi = 0;
  int wait_left = 0;
  bit armed = 0;
  bit rst_seen = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endfunction

  // Monitor + memory responder: decides mem_ready, compares against the scoreboard.
  always @(negedge clk) begin : mon
    bus_t  b;
    done_t r;
    mem_ready = 1'b0;
    if (reset) begin
      exp_q.delete();
      done_q.delete();
      armed    = 0;
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk("rst_ctrl",  {28'b0, busy, done, error, mem_valid}, 32'h0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
        rst_seen = 0;
      end
      chk("mem_instr", 32'(mem_instr), 32'h0);
      if (mem_valid) begin
        if (!armed) begin
          wait_left = $urandom_range(lat_hi, lat_lo);
          armed = 1;
        end
        if (hs_count >= stuck_at) mem_ready = 1'b0;
        else if (wait_left > 0) wait_left--;
        else begin
          mem_ready = 1'b1;
          armed = 0;
        end
        mem_rdata = mem_rd(mem_addr);
        chk("busy_in_xfer", 32'(busy), 32'h1);
        chk("error_in_xfer", 32'(error), 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'(mem_valid), 32'h0);
        end else begin
          b = exp_q[0];
          chk(b.wr ? "wr_addr" : "rd_addr", mem_addr, b.addr);
          chk("wstrb", {28'b0, mem_wstrb}, b.wr ? 32'hF : 32'h0);
          if (b.wr) chk("wr_data", mem_wdata, b.data);
          if (mem_ready) void'(exp_q.pop_front());
        end
        if (mem_ready) begin
          hs_count++;
          if (mem_wstrb == 4'hF) mem[mem_addr] = mem_wdata;
        end
      end else begin
        armed = 0;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          r = done_q.pop_front();
          chk("done_error", 32'(error), 32'(r.err));
          if (r.cyc >= 0) chk("done_cycle", cyc, r.cyc);
          chk("done_busy", 32'(busy), 32'h0);
          chk("done_valid", 32'(mem_valid), 32'h0);
          if (r.aborted) begin
            chk("abort_pending", 32'(exp_q.size()), 32'h1);
            exp_q.delete();
          end else begin
            chk("leftover_req", 32'(exp_q.size()), 32'h0);
          end
          jobs_done++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scramble();
    src_addr  = $urandom;
    dst_addr  = $urandom;
    len_words = LW'($urandom);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a]  = v;
    refm[a] = v;
  endtask

  task automatic pulse(input logic [31:0] s, input logic [31:0] d, input int n);
    src_addr = s; dst_addr = d; len_words = LW'(n);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    scramble();
  endtask

  // Reference model: ascending word copy; hs_limit>=0 means the responder
  // never completes handshake number hs_limit of this job.
  task automatic issue_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int hs_limit, input bit chk_cyc, input bit will_reset,
                           output int t0, output int target);
    done_t r;
    bus_t  b;
    logic [31:0] a;
    logic [31:0] rv;
    bit bad;
    int k;
    bad    = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    t0     = cyc;
    target = jobs_done + 1;
    r.err = bad; r.aborted = 0; r.cyc = -1;
    rv = '0;
    if (bad || n == 0) begin
      r.cyc = t0 + 1;
    end else begin
      k = 0;
      for (int i = 0; i < n; i++) begin
        for (int w = 0; w < 2; w++) begin
          if (hs_limit < 0 || k <= hs_limit) begin
            if (w == 0) begin
              a = s + 32'(4 * i);
              rv = ref_rd(a);
              b.wr = 0; b.addr = a; b.data = '0;
            end else begin
              a = d + 32'(4 * i);
              b.wr = 1; b.addr = a; b.data = rv;
              if (hs_limit < 0 || k < hs_limit) refm[a] = rv;
            end
            exp_q.push_back(b);
          end
          k++;
        end
      end
      if (hs_limit >= 0) begin
        r.err = 1; r.aborted = 1;
        if (chk_cyc) r.cyc = t0 + 1 + hs_limit * (lat_hi + 1) + TMO;
        stuck_at = hs_count + hs_limit;
      end else if (chk_cyc) begin
        r.cyc = t0 + 1 + 2 * n * (lat_hi + 1);
      end
    end
    if (!will_reset) done_q.push_back(r);
    pulse(s, d, n);
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 0;
    while (jobs_done < target) begin
      tick(1);
      budget++;
      if (budget > 2000) begin
        $display("FAIL wait_done: no done after %0d cycles, jobs %0d want %0d", budget, jobs_done, target);
        $fatal(1, "bench stalled");
      end
    end
    tick(2);
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int hs_limit, input bit chk_cyc);
    int t0, target;
    issue_job(s, d, n, hs_limit, chk_cyc, 1'b0, t0, target);
    wait_done(target);
    stuck_at = 1 << 30;
  endtask

  initial begin : driver
    int t0, target;
    logic [31:0] s, d;
    int n;
    start = 1'b0; reset = 1'b1;
    src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick(2);

    // T1: three words, always ready
    preload(32'h100, 32'hA000_000A);
    preload(32'h104, 32'hB000_000B);
    preload(32'h108, 32'hC000_000C);
    lat_lo = 0; lat_hi = 0;
    run_job(32'h100, 32'h200, 3, -1, 1'b1);

    // T2: three stall cycles per request
    preload(32'h140, 32'h1234_5678);
    preload(32'h144, 32'h9ABC_DEF0);
    lat_lo = 3; lat_hi = 3;
    run_job(32'h140, 32'h240, 2, -1, 1'b1);
    lat_lo = 0; lat_hi = 0;

    // T3: misaligned source, then a good job clears error
    run_job(32'h102, 32'h200, 3, -1, 1'b1);
    run_job(32'h100, 32'h222 & 32'hFFFF_FFFC, 1, -1, 1'b1);
    run_job(32'h100, 32'h201, 2, -1, 1'b1);

    // T4: zero length; starts while busy and in the DONE cycle are dropped
    run_job(32'h100, 32'h300, 0, -1, 1'b1);
    issue_job(32'h100, 32'h320, 5, -1, 1'b1, 1'b0, t0, target);
    tick(3);
    pulse(32'h700, 32'h780, 3);
    while (cyc < t0 + 11) tick(1);
    pulse(32'h700, 32'h7C0, 3);
    wait_done(target);
    tick(4);

    // T5: responder hangs on the second read
    preload(32'h500, 32'h5555_0000);
    preload(32'h504, 32'h5555_0001);
    run_job(32'h500, 32'h580, 3, 2, 1'b1);
    tick(3);

    // T6: reset while a write is stalled, then a wrapping copy
    issue_job(32'h600, 32'h680, 4, 3, 1'b0, 1'b1, t0, target);
    while (cyc < t0 + 6) tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    stuck_at = 1 << 30;
    tick(4);
    preload(32'hFFFF_FFFC, 32'hFEED_0001);
    preload(32'h0000_0000, 32'hFEED_0002);
    run_job(32'hFFFF_FFFC, 32'h400, 2, -1, 1'b1);

    // Randomized jobs, including overlapping ranges and occasional misalignment
    for (int j = 0; j < 24; j++) begin
      s = 32'h1000 + 32'($urandom_range(40) * 4);
      d = 32'h1000 + 32'($urandom_range(40) * 4);
      if ($urandom_range(7) == 0) s = s | 32'h2;
      if ($urandom_range(7) == 0) d = d | 32'h1;
      n = $urandom_range(6, 0);
      lat_lo = 0;
      lat_hi = $urandom_range(4, 0);
      run_job(s, d, n, -1, lat_hi == 0);
    end
    lat_hi = 0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
